// File: rtl/rr_sel4_pkg.sv
// Shared types and constants for the rr_sel4 packet-locked round-robin selector.
// No logic; combinational helper only, no latency or flow control of its own.
package rr_sel4_pkg;

    localparam int RR_N     = 4;
    localparam int RR_IDX_W = 2;
    localparam int RR_CNT_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [RR_N-1:0] idx2oh(input logic [RR_IDX_W-1:0] i_idx);
        return RR_N'(1) << i_idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req scanning ptr+1, ptr+2, ptr+3, ptr.
// Purely combinational, zero latency; no flow control.
module rr_pick4
    import rr_sel4_pkg::*;
(
    input  logic [RR_N-1:0]     req,
    input  logic [RR_IDX_W-1:0] ptr,
    output logic                any,
    output logic [RR_IDX_W-1:0] idx
);

    logic                w_found;
    logic [RR_IDX_W-1:0] w_cand;

    always_comb begin
        any     = |req;
        idx     = ptr;
        w_found = 1'b0;
        w_cand  = ptr;
        // k = RR_N wraps back to ptr itself, giving it the lowest priority
        for (int k = 1; k <= RR_N; k++) begin
            w_cand = ptr + RR_IDX_W'(k);
            if (!w_found && req[w_cand]) begin
                idx     = w_cand;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel4.sv
// Packet-locked 4-way round-robin mux select; s/gnt registered (1 cycle from req), valid/ack combinational.
// Lock held across ready=0 and req dropout; optional idle-timeout release with RR_SEL4_TIMEOUT_EN.
module rr_sel4
    import rr_sel4_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RR_N-1:0]     req,
    input  logic [RR_N-1:0]     last,
    input  logic                ready,
    output logic [RR_IDX_W-1:0] s,
    output logic [RR_N-1:0]     gnt,
    output logic                valid,
    output logic [RR_N-1:0]     ack
);

    state_t              r_state, w_state_nxt;
    logic [RR_IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [RR_IDX_W-1:0] r_s, w_s_nxt;
    logic [RR_N-1:0]     r_gnt, w_gnt_nxt;

    logic                w_locked;
    logic                w_xfer;
    logic                w_rel_last;
    logic                w_rel_to;
    logic                w_release;
    logic [RR_IDX_W-1:0] w_pick_ptr;
    logic                w_any;
    logic [RR_IDX_W-1:0] w_idx;

    assign w_locked   = (r_state == ST_LOCKED);
    assign valid      = w_locked & req[r_s];
    assign w_xfer     = valid & ready;
    assign ack        = r_gnt & {RR_N{w_xfer}};
    assign w_rel_last = w_xfer & last[r_s];
    assign w_release  = w_rel_last | w_rel_to;

    assign s   = r_s;
    assign gnt = r_gnt;

`ifdef RR_SEL4_TIMEOUT_EN
    logic [RR_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

    assign w_cnt_inc = r_cnt + RR_CNT_W'(1);
    assign w_rel_to  = w_locked & ~req[r_s] & (w_cnt_inc == RR_CNT_W'(TIMEOUT));

    always_comb begin
        w_cnt_nxt = w_cnt_inc;
        if (!w_locked || w_release || req[r_s]) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    assign w_rel_to = 1'b0;
`endif

    // On release the just-served requester becomes the pointer, so it scans last
    assign w_pick_ptr = w_locked ? r_s : r_ptr;

    rr_pick4 u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_s_nxt     = r_s;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_LOCKED;
                    w_s_nxt     = w_idx;
                    w_gnt_nxt   = idx2oh(w_idx);
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_ptr_nxt = r_s;
                    if (w_any) begin
                        w_s_nxt   = w_idx;
                        w_gnt_nxt = idx2oh(w_idx);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= RR_IDX_W'(RR_N - 1);
            r_s     <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_s     <= w_s_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_sel4.sv
// Scoreboard bench for rr_sel4: reference model pushes expected outputs per cycle, negedge monitor compares.
// Directed scenarios plus a random segment; TIMEOUT fixed at 4.
module tb_rr_sel4;

    localparam int TO_VAL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] ack;

    always #5 clk = ~clk;

    rr_sel4 #(.TIMEOUT(TO_VAL)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .last  (last),
        .ready (ready),
        .s     (s),
        .gnt   (gnt),
        .valid (valid),
        .ack   (ack)
    );

    typedef struct packed {
        logic [1:0] s;
        logic [3:0] gnt;
        logic       valid;
        logic [3:0] ack;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    int   m_locked;
    int   m_s;
    int   m_ptr;
    int   m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_locked = 0;
        m_s      = 0;
        m_ptr    = 3;
        m_cnt    = 0;
    endtask

    task automatic m_update();
        int  w;
        logic mv, rel, to;
        mv  = (m_locked != 0) && req[m_s];
        rel = mv && ready && last[m_s];
        to  = 1'b0;
`ifdef RR_SEL4_TIMEOUT_EN
        to  = (m_locked != 0) && !req[m_s] && (m_cnt + 1 == TO_VAL);
`endif
        if (m_locked == 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_locked = 1;
                m_s      = w;
                m_cnt    = 0;
            end
        end else if (rel || to) begin
            m_ptr = m_s;
            m_cnt = 0;
            w = pick(req, m_s);
            if (w >= 0) m_s = w;
            else m_locked = 0;
        end else if (req[m_s]) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.s     = 2'(m_s);
        e.gnt   = (m_locked != 0) ? 4'(1 << m_s) : 4'b0000;
        e.valid = (m_locked != 0) && req[m_s];
        e.ack   = (e.valid && ready) ? e.gnt : 4'b0000;
        sb_q.push_back(e);
    endtask

    // Advance one cycle: model absorbs the edge, then new inputs are driven and their expectation queued
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lst, input logic rdy);
        @(posedge clk);
        if (rst) m_reset();
        else m_update();
        #1;
        rst   = r;
        req   = rq;
        last  = lst;
        ready = rdy;
        if (r) m_reset();
        push_exp();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_s",     32'(s),     32'(e.s));
            chk("sb_gnt",   32'(gnt),   32'(e.gnt));
            chk("sb_valid", 32'(valid), 32'(e.valid));
            chk("sb_ack",   32'(ack),   32'(e.ack));
        end
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        last  = '0;
        ready = 1'b0;
        m_reset();

        repeat (2) step(1'b1, 4'b0000, 4'b0000, 1'b0);
        #3;
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_s",     32'(s),     32'h0);
        chk("rst_valid", 32'(valid), 32'h0);

        // first pick
        step(1'b0, 4'b1010, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, 1'b1);
        #3;
        chk("first_s",     32'(s),     32'h1);
        chk("first_gnt",   32'(gnt),   32'h2);
        chk("first_valid", 32'(valid), 32'h1);

        // three-beat packet on requester 1
        step(1'b0, 4'b1111, 4'b0000, 1'b1);
        #3 chk("lock_s2", 32'(s), 32'h1);
        step(1'b0, 4'b1111, 4'b0010, 1'b1);
        #3 chk("lock_s3", 32'(s), 32'h1);

        // handover to 2, then backpressure and dropout
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        #3 chk("hand_s", 32'(s), 32'h2);
        repeat (3) begin
            step(1'b0, 4'b1111, 4'b0000, 1'b0);
            #3;
            chk("bp_s",   32'(s),   32'h2);
            chk("bp_ack", 32'(ack), 32'h0);
        end
        repeat (3) begin
            step(1'b0, 4'b1011, 4'b0100, 1'b1);
            #3;
            chk("drop_gnt", 32'(gnt), 32'h4);
            chk("drop_ack", 32'(ack), 32'h0);
        end
        step(1'b0, 4'b1111, 4'b0100, 1'b1);
        #3 chk("resume_ack", 32'(ack), 32'h4);

        // fairness with single-beat packets
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b1111, 4'b1111, 1'b1);
            #3;
            chk("fair_s",   32'(s),            32'((3 + k) % 4));
            chk("fair_ack", 32'($onehot(ack)), 32'h1);
        end
        step(1'b0, 4'b1001, 4'b1000, 1'b1);
        #3 chk("fair_end_s", 32'(s), 32'h3);

        // sole requester re-granted back to back
        repeat (6) begin
            step(1'b0, 4'b0001, 4'b0001, 1'b1);
            #3;
            chk("sole_s",   32'(s),   32'h0);
            chk("sole_ack", 32'(ack), 32'h1);
        end

        // last on a non-selected requester does not release
        step(1'b0, 4'b1001, 4'b0001, 1'b1);
        step(1'b0, 4'b1001, 4'b0111, 1'b1);
        #3 chk("ign_s", 32'(s), 32'h3);
        step(1'b0, 4'b1001, 4'b1000, 1'b1);
        #3 chk("ign_hold_s", 32'(s), 32'h3);
        step(1'b0, 4'b1001, 4'b0001, 1'b1);
        #3 chk("ign_next_s", 32'(s), 32'h0);

`ifdef RR_SEL4_TIMEOUT_EN
        step(1'b0, 4'b1001, 4'b0000, 1'b1);
        #3 chk("to_lock_s", 32'(s), 32'h3);
        repeat (TO_VAL) begin
            step(1'b0, 4'b0001, 4'b0000, 1'b1);
            #3;
            chk("to_wait_s", 32'(s),   32'h3);
            chk("to_ack",    32'(ack), 32'h0);
        end
        step(1'b0, 4'b0001, 4'b0001, 1'b1);
        #3 chk("to_rel_s", 32'(s), 32'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0));
        end

        // asynchronous reset mid-packet
        step(1'b0, 4'b1111, 4'b0000, 1'b1);
        step(1'b0, 4'b1111, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 4'b0000, 1'b1);
        #3;
        chk("arst_gnt",   32'(gnt),   32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        step(1'b0, 4'b1111, 4'b1111, 1'b1);
        #3 chk("post_rst_gnt", 32'(gnt), 32'h0);
        step(1'b0, 4'b1111, 4'b1111, 1'b1);
        #3 chk("post_rst_s", 32'(s), 32'h0);

        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
